// File: rtl/alu_result_checker.sv
// Result checker for an ALU under test: expected hi/lo/zero ride a LAT-deep delay line and are compared with the DUT outputs.
// Define ALU_CHK_FIRSTFAIL_EN to capture the index and lo words of the first mismatch in each run.
module alu_result_checker #(
    parameter int LAT   = 1,
    parameter int VEC_W = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             vec_last,
    input  logic [VEC_W-1:0] vec_idx,
    input  logic [31:0]      exp_hi,
    input  logic [31:0]      exp_lo,
    input  logic             exp_zero,
    input  logic [31:0]      dut_hi,
    input  logic [31:0]      dut_lo,
    input  logic             dut_zero,
    input  logic [1:0]       disp_sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      errors,
    output logic [31:0]      disp_word
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     state;
    logic [1:0]     state_nxt;

    logic [LAT-1:0] pipe_valid;
    logic [LAT-1:0] pipe_last;
    logic [LAT-1:0] pipe_zero;
    logic [31:0]    pipe_hi [LAT];
    logic [31:0]    pipe_lo [LAT];

    logic           start_ok;
    logic           accept;
    logic           out_valid;
    logic           out_last;
    logic           mismatch;

    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign accept    = vec_valid && (state == S_RUN);
    assign out_valid = pipe_valid[LAT-1];
    assign out_last  = pipe_last[LAT-1];
    assign mismatch  = out_valid &&
                       ((dut_hi   != pipe_hi[LAT-1]) ||
                        (dut_lo   != pipe_lo[LAT-1]) ||
                        (dut_zero != pipe_zero[LAT-1]));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && vec_last) state_nxt = S_DRAIN;
            S_DRAIN: if (out_valid && out_last) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only the valid bits need clearing; payload is ignored wherever valid is low.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
        end else if (start_ok) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        pipe_last[0] <= vec_last;
        pipe_zero[0] <= exp_zero;
        pipe_hi[0]   <= exp_hi;
        pipe_lo[0]   <= exp_lo;
        for (int i = 1; i < LAT; i++) begin
            pipe_last[i] <= pipe_last[i-1];
            pipe_zero[i] <= pipe_zero[i-1];
            pipe_hi[i]   <= pipe_hi[i-1];
            pipe_lo[i]   <= pipe_lo[i-1];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            errors <= '0;
        end else if (start_ok) begin
            errors <= '0;
        end else if (mismatch && (errors != 32'hFFFF_FFFF)) begin
            errors <= errors + 32'd1;
        end
    end

`ifdef ALU_CHK_FIRSTFAIL_EN
    logic [VEC_W-1:0] pipe_idx [LAT];
    logic             ff_seen;
    logic [VEC_W-1:0] ff_idx;
    logic [31:0]      ff_dut_lo;
    logic [31:0]      ff_exp_lo;

    always_ff @(posedge CLOCK_50) begin
        pipe_idx[0] <= vec_idx;
        for (int i = 1; i < LAT; i++) begin
            pipe_idx[i] <= pipe_idx[i-1];
        end
    end

    // ff_seen locks the record so later mismatches in the same run leave it alone.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ff_seen   <= 1'b0;
            ff_idx    <= '0;
            ff_dut_lo <= '0;
            ff_exp_lo <= '0;
        end else if (start_ok) begin
            ff_seen   <= 1'b0;
            ff_idx    <= '0;
            ff_dut_lo <= '0;
            ff_exp_lo <= '0;
        end else if (mismatch && !ff_seen) begin
            ff_seen   <= 1'b1;
            ff_idx    <= pipe_idx[LAT-1];
            ff_dut_lo <= dut_lo;
            ff_exp_lo <= pipe_lo[LAT-1];
        end
    end
`else
    // The index only matters to the first-fail record, so it is otherwise dropped here.
    logic unused_idx;
    assign unused_idx = ^vec_idx;
`endif

    always_comb begin
        disp_word = '0;
        case (disp_sel)
            2'd0: disp_word = errors;
`ifdef ALU_CHK_FIRSTFAIL_EN
            2'd1: disp_word = 32'(ff_idx);
            2'd2: disp_word = ff_dut_lo;
            2'd3: disp_word = ff_exp_lo;
`endif
            default: disp_word = '0;
        endcase
    end

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign pass = done && (errors == 32'd0);

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter LAT, default 1, meaning: DUT result latency in CLOCK_50 cycles from vector presentation; legal range 1..4.
REQ-002 Parameter VEC_W, default 8, meaning: width of vector index.
REQ-003 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse starting a check run.
REQ-006 vec_valid  input  1  expected values and vec_idx valid this cycle; the same vector is on the DUT inputs this cycle.
REQ-007 vec_last  input  1  qualifies vec_valid as the final vector of the run.
REQ-008 vec_idx  input  VEC_W  index of the presented vector.
REQ-009 exp_hi, exp_lo  input  32 each  expected DUT hi/lo.
REQ-010 exp_zero  input  1  expected DUT zero flag.
REQ-011 dut_hi, dut_lo  input  32 each  DUT hi/lo outputs.
REQ-012 dut_zero  input  1  DUT zero output.
REQ-013 disp_sel  input  2  display word select.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 done  output  1  high in DONE.
REQ-016 pass  output  1  done and errors == 0.
REQ-017 errors  output  32  mismatch count.
REQ-018 disp_word  output  32  word for the eight-digit hex display.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE after reset.
REQ-020 start in IDLE or DONE: next state RUN; errors, first-fail record and delay line cleared in the same edge; start in RUN/DRAIN is ignored.
REQ-021 Vector acceptance: vec_valid sampled high in RUN only; in IDLE, DRAIN and DONE vec_valid is ignored and nothing enters the delay line.
REQ-022 Accepted vectors enter a LAT-deep delay line carrying valid, last, idx, exp_hi, exp_lo, exp_zero; one entry per cycle, no backpressure.
REQ-023 Compare: when the delay-line output is valid, dut_{hi,lo,zero} sampled that cycle (LAT cycles after acceptance) are compared bitwise with the delayed expected values; any differing bit is a mismatch.
REQ-024 Mismatch increments errors by 1, saturating at 32'hFFFF_FFFF.
REQ-025 Accepted vec_last moves RUN to DRAIN on the same edge.
REQ-026 DRAIN to DONE on the edge where the delayed last entry is compared; that compare is counted before done rises.
REQ-027 Back-to-back vectors every cycle are compared every cycle with no loss.
REQ-028 disp_sel 0: errors; 1: first-fail idx zero-extended; 2: first-fail dut_lo; 3: first-fail exp_lo (see REQ-033).
REQ-029 disp_word is combinational from registers and disp_sel only.

Reset
REQ-030 reset asserted: state IDLE, delay line valid bits 0, errors 0, first-fail record 0, busy 0, done 0, pass 0, disp_word 0 for any disp_sel.
REQ-031 reset mid-run (RUN or DRAIN) discards all in-flight entries; no compare occurs until a new start.
REQ-032 Deasserting reset takes effect on the next CLOCK_50 rising edge; no start accepted in the reset-release cycle if reset is high at that edge.

Configuration
REQ-033 Macro ALU_CHK_FIRSTFAIL_EN defined: first mismatch of a run captures idx, dut_lo, exp_lo; later mismatches do not overwrite until the next start/reset.
REQ-034 ALU_CHK_FIRSTFAIL_EN undefined: no capture registers exist; disp_sel 1..3 returns 32'h0; all other behaviour identical.

Verification
REQ-035 LAT=1, start, 3 vectors idx 0..2 all matching, last on idx 2 -> done high 2 cycles after idx 2 accepted, errors=0, pass=1.
REQ-036 LAT=1, 5 back-to-back vectors, idx 1 and 3 dut_lo differing by bit 0 -> errors=2, pass=0; with macro disp_sel=1 gives 1, disp_sel=2/3 give the idx-1 values.
REQ-037 LAT=3, vec_valid every cycle, only dut_zero wrong on idx 4 of 8 -> errors=1, done exactly 4 cycles after last accepted.
REQ-038 Assert reset while in DRAIN with 2 entries in flight -> IDLE, errors=0, disp_word=0; later mismatching DUT values cause no increment.
REQ-039 Preload errors near saturation (force 32'hFFFF_FFFE), 3 mismatches -> errors=32'hFFFF_FFFF.
REQ-040 start pulsed in RUN and vec_valid in DONE -> both ignored; start in DONE -> errors cleared, RUN re-entered.
